posit_accum_sched: RTL and testbench

//  Slot scheduler sharing one pipelined posit accumulator (loop latency LAT) among NREQ term streams.

---
 rtl/posit_accum_sched.sv | 145 ++++++++++++++
 tb/tb_posit_accum_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_accum_sched.sv
// posit_accum_sched: shares one pipelined posit accumulator among NREQ term streams, one context slot per pipeline stage.
// Define POSIT_ACCUM_SCHED_STATS_EN to add the stat_beats/stat_bubbles/stat_sums counters.
module posit_accum_sched #(
  parameter int NBITS = 32,
  parameter int LAT = 8,
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int SW = (LAT > 1) ? $clog2(LAT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*NBITS-1:0] in_data,
  input  logic [NREQ-1:0]       in_last,
  output logic [NREQ-1:0]       in_ready,
  output logic [NBITS-1:0]      acc_in,
  output logic                  acc_start,
  input  logic [NBITS-1:0]      acc_result,
  input  logic                  acc_inf,
  input  logic                  acc_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBITS-1:0]      out_data,
  output logic [IW-1:0]         out_id,
  output logic                  out_inf,
`ifdef POSIT_ACCUM_SCHED_STATS_EN
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_bubbles,
  output logic [31:0]           stat_sums,
`endif
  output logic                  err_dead
);
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2, DEAD = 2'd3;
  logic [SW-1:0] s_q, s_d;
  logic [1:0] st_q [LAT];
  logic [1:0] st_d [LAT];
  logic [IW-1:0] own_q [LAT];
  logic [IW-1:0] own_d [LAT];
  logic [NREQ-1:0] held_q, held_d;
  logic [IW-1:0] rr_q, rr_d;
  logic err_q, err_d;
  logic [NBITS-1:0] cur;
  logic [IW-1:0] ow, gnt, ix;
  logic gnt_v;
  assign acc_start = rst_n;
  assign err_dead = err_q;
  always_comb begin
    cur = acc_done ? acc_result : '0;
    ow = own_q[s_q];
    gnt = '0;
    gnt_v = 1'b0;
    ix = '0;
    // Descending scan so the candidate closest to the round-robin pointer wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      ix = IW'((int'(rr_q) + i) % NREQ);
      if (in_valid[ix] && !held_q[ix]) begin
        gnt = ix;
        gnt_v = 1'b1;
      end
    end
    s_d = (s_q == SW'(LAT - 1)) ? '0 : s_q + 1'b1;
    st_d = st_q;
    own_d = own_q;
    held_d = held_q;
    rr_d = rr_q;
    err_d = err_q;
    acc_in = '0;
    in_ready = '0;
    out_valid = 1'b0;
    out_inf = 1'b0;
    out_data = cur;
    out_id = ow;
    if (rst_n) begin
      case (st_q[s_q])
        FREE: if (gnt_v) begin
          acc_in = in_data[int'(gnt)*NBITS +: NBITS];
          in_ready[gnt] = 1'b1;
          st_d[s_q] = in_last[gnt] ? DRAIN : BUSY;
          own_d[s_q] = gnt;
          held_d[gnt] = 1'b1;
          rr_d = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        end
        BUSY: if (in_valid[ow]) begin
          acc_in = in_data[int'(ow)*NBITS +: NBITS];
          in_ready[ow] = 1'b1;
          st_d[s_q] = in_last[ow] ? DRAIN : BUSY;
        end
        DRAIN: begin
          out_valid = 1'b1;
          out_inf = acc_inf;
          if (out_ready) begin
            held_d[ow] = 1'b0;
            st_d[s_q] = acc_inf ? DEAD : FREE;
            err_d = err_q | acc_inf;
            // Feeding back the exact negation zeroes the slot's context for its next owner
            acc_in = acc_inf ? '0 : -cur;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      st_q <= '{default: FREE};
      own_q <= '{default: '0};
      held_q <= '0;
      rr_q <= '0;
      err_q <= 1'b0;
    end else begin
      s_q <= s_d;
      st_q <= st_d;
      own_q <= own_d;
      held_q <= held_d;
      rr_q <= rr_d;
      err_q <= err_d;
    end
  end
`ifdef POSIT_ACCUM_SCHED_STATS_EN
  logic [31:0] beats_q, beats_d, bub_q, bub_d, sums_q, sums_d;
  logic bubble;
  always_comb begin
    bubble = rst_n && (((st_q[s_q] == BUSY) && !(|in_ready)) ||
                       ((st_q[s_q] == DRAIN) && !(out_ready && !acc_inf)));
    beats_d = ((|in_ready) && !(&beats_q)) ? beats_q + 32'd1 : beats_q;
    bub_d = (bubble && !(&bub_q)) ? bub_q + 32'd1 : bub_q;
    sums_d = (out_valid && out_ready && !(&sums_q)) ? sums_q + 32'd1 : sums_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
      bub_q <= '0;
      sums_q <= '0;
    end else begin
      beats_q <= beats_d;
      bub_q <= bub_d;
      sums_q <= sums_d;
    end
  end
  assign stat_beats = beats_q;
  assign stat_bubbles = bub_q;
  assign stat_sums = sums_q;
`endif
endmodule

// File: tb/tb_posit_accum_sched.sv
// tb_posit_accum_sched: directed bench with a behavioural posit32 accumulator, requester queues and a sum recorder.
module tb_posit_accum_sched;
  localparam int NB = 32, LAT = 8, NR = 4;
  localparam logic [31:0] NAR = 32'h8000_0000, PH = 32'h3800_0000, P1 = 32'h4000_0000,
                          P2 = 32'h4800_0000, P3 = 32'h4C00_0000, P5 = 32'h5200_0000, P6 = 32'h5400_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [NR-1:0] in_valid = '0, in_last = '0, in_ready;
  logic [NR*NB-1:0] in_data = '0;
  logic [NB-1:0] acc_in, acc_result, out_data;
  logic acc_start, acc_inf, acc_done, out_valid, out_inf, err_dead;
  logic out_ready = 1'b1;
  logic [1:0] out_id;
`ifdef POSIT_ACCUM_SCHED_STATS_EN
  logic [31:0] stat_beats, stat_bubbles, stat_sums;
  logic [31:0] b0;
`endif
  posit_accum_sched #(.NBITS(NB), .LAT(LAT), .NREQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .acc_in(acc_in), .acc_start(acc_start), .acc_result(acc_result),
    .acc_inf(acc_inf), .acc_done(acc_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_inf(out_inf),
`ifdef POSIT_ACCUM_SCHED_STATS_EN
    .stat_beats(stat_beats), .stat_bubbles(stat_bubbles), .stat_sums(stat_sums),
`endif
    .err_dead(err_dead));

  function automatic real p2r(input logic [31:0] pin);
    logic [31:0] p, x;
    logic neg;
    int m, k, sc;
    real v;
    if (pin == 32'd0 || pin == NAR) return 0.0;
    neg = pin[31];
    p = neg ? ~pin + 32'd1 : pin;
    x = p << 1;
    m = 0;
    while (m < 31 && x[31-m] == x[31]) m++;
    k = x[31] ? m - 1 : -m;
    x = x << (m + 1);
    sc = 4 * k + int'(x[31:30]);
    v = 1.0 + real'(x[29:0]) / 1073741824.0;
    for (int i = 0; i < sc; i++) v = v * 2.0;
    for (int i = 0; i > sc; i--) v = v / 2.0;
    return neg ? -v : v;
  endfunction

  function automatic logic [31:0] r2p(input real vin);
    real a, f;
    int sc, k, e, pos;
    logic [63:0] w;
    logic [31:0] res;
    if (vin == 0.0) return 32'd0;
    a = (vin < 0.0) ? -vin : vin;
    sc = 0;
    while (a >= 2.0) begin a = a / 2.0; sc++; end
    while (a < 1.0) begin a = a * 2.0; sc--; end
    k = (sc >= 0) ? sc / 4 : -((-sc + 3) / 4);
    e = sc - 4 * k;
    w = '0;
    pos = 63;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin w[pos] = 1'b1; pos--; end
      pos--;
    end else begin
      pos = pos + k;
      w[pos] = 1'b1;
      pos--;
    end
    w[pos] = e[1];
    w[pos-1] = e[0];
    pos = pos - 2;
    f = a - 1.0;
    while (pos >= 0) begin
      f = f * 2.0;
      if (f >= 1.0) begin w[pos] = 1'b1; f = f - 1.0; end
      pos--;
    end
    res = {1'b0, w[63:33]};
    return (vin < 0.0) ? ~res + 32'd1 : res;
  endfunction

  // Accumulator: result(c+LAT) = cur(c) + acc_in(c), NaR sticky per context
  real pr [LAT];
  logic pi [LAT];
  logic pd [LAT];
  assign acc_done = pd[LAT-1];
  assign acc_inf = pd[LAT-1] && pi[LAT-1];
  always_comb acc_result = pi[LAT-1] ? NAR : r2p(pr[LAT-1]);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin pr[i] <= 0.0; pi[i] <= 1'b0; pd[i] <= 1'b0; end
    end else begin
      pr[0] <= (acc_done ? pr[LAT-1] : 0.0) + p2r(acc_in);
      pi[0] <= (acc_done && pi[LAT-1]) || (acc_in == NAR);
      pd[0] <= acc_start;
      for (int i = 1; i < LAT; i++) begin pr[i] <= pr[i-1]; pi[i] <= pi[i-1]; pd[i] <= pd[i-1]; end
    end
  end

  logic [31:0] qd [NR][32];
  logic ql [NR][32];
  int qh [NR], qt [NR];
  logic hold [NR];
  int pop_cyc [NR][32], pop_cnt [NR];
  int gord [64], gcnt, nsum, ov_cnt, viol, cyc, dead_slot, dead_hits;
  int rec_cyc [64], ov_cyc [64];
  logic [31:0] rec_data [64], ov_data [64];
  logic [1:0] rec_id [64], ov_id [64];
  logic rec_inf [64];
  int n_chk = 0, n_fail = 0;
  int d, slot_e;

  always @(posedge clk) if (rst_n) begin
    if ($countones(in_ready) > 1) viol++;
    for (int r = 0; r < NR; r++) if (in_ready[r]) begin
      if (!in_valid[r]) viol++;
      if (pop_cnt[r] < 32) pop_cyc[r][pop_cnt[r]] = cyc;
      pop_cnt[r]++;
      if (gcnt < 64) gord[gcnt] = r;
      gcnt++;
      if (cyc % LAT == dead_slot) dead_hits++;
      qh[r]++;
    end
    if (out_valid) begin
      if (ov_cnt < 64) begin ov_cyc[ov_cnt] = cyc; ov_data[ov_cnt] = out_data; ov_id[ov_cnt] = out_id; end
      ov_cnt++;
    end
    if (out_valid && out_ready) begin
      if (nsum < 64) begin
        rec_cyc[nsum] = cyc; rec_data[nsum] = out_data; rec_id[nsum] = out_id; rec_inf[nsum] = out_inf;
      end
      nsum++;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      in_valid[r] = (qh[r] != qt[r]) && !hold[r];
      in_data[r*NB +: NB] = qd[r][qh[r] % 32];
      in_last[r] = ql[r][qh[r] % 32];
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
  endtask

  task automatic push(input int r, input logic [31:0] v, input logic l);
    qd[r][qt[r] % 32] = v;
    ql[r][qt[r] % 32] = l;
    qt[r]++;
  endtask

  task automatic clr();
    nsum = 0; ov_cnt = 0; gcnt = 0;
    for (int r = 0; r < NR; r++) pop_cnt[r] = 0;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    clr();
    cyc = 0; viol = 0; dead_hits = 0;
    for (int r = 0; r < NR; r++) begin qh[r] = 0; qt[r] = 0; hold[r] = 1'b0; end
    drive();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sums(input int n, input int budget, input string tag);
    int i = 0;
    while (nsum < n && i < budget) begin step(); i++; end
    chk(tag, nsum, n);
  endtask

  task automatic wait_ov(input int n, input int budget, input string tag);
    int i = 0;
    while (ov_cnt < n && i < budget) begin step(); i++; end
    chk(tag, ov_cnt, n);
  endtask

  task automatic wait_pops(input int r, input int n, input int budget, input string tag);
    int i = 0;
    while (pop_cnt[r] < n && i < budget) begin step(); i++; end
    chk(tag, pop_cnt[r], n);
  endtask

  initial begin
    dead_slot = -1;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < 32; k++) begin qd[r][k] = '0; ql[r][k] = 1'b0; end
    // Reset state with a request already pending, then 1+2+3
    enter_reset();
    push(0, P1, 1'b0); push(0, P2, 1'b0); push(0, P3, 1'b1);
    drive();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_acc_in", acc_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_dead", err_dead, 0);
    rst_n = 1'b1;
    step();
    chk("acc_start_run", acc_start, 1);
    wait_sums(1, 60, "a_sum_cnt");
    chk("a_data", rec_data[0], P6);
    chk("a_id", rec_id[0], 0);
    chk("a_inf", rec_inf[0], 0);
    chk("a_pop0_cyc", pop_cyc[0][0], 0);
    chk("a_pop2_cyc", pop_cyc[0][2], 2 * LAT);
    chk("a_sum_cyc", rec_cyc[0], 3 * LAT);
`ifdef POSIT_ACCUM_SCHED_STATS_EN
    chk("a_stat_beats", stat_beats, 3);
    chk("a_stat_sums", stat_sums, 1);
`endif
    // Four requesters, 0.5 x4 each
    enter_reset();
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < 4; k++) push(r, PH, k == 3);
    drive();
    rst_n = 1'b1;
    wait_sums(4, 80, "b_sum_cnt");
    for (int i = 0; i < 4; i++) begin
      chk("b_grant_order", gord[i], i);
      chk("b_data", rec_data[i], P2);
      chk("b_id", rec_id[i], i);
    end
    // Bubbles: req1 idles for three visits mid-batch
    clr();
    push(1, P1, 1'b0); push(1, P1, 1'b0); push(1, P1, 1'b1);
    drive();
`ifdef POSIT_ACCUM_SCHED_STATS_EN
    b0 = stat_bubbles;
`endif
    wait_pops(1, 1, 40, "c_first_pop");
    hold[1] = 1'b1;
    drive();
    repeat (3 * LAT) step();
    hold[1] = 1'b0;
    drive();
    wait_sums(1, 80, "c_sum_cnt");
    chk("c_data", rec_data[0], P3);
    chk("c_id", rec_id[0], 1);
    chk("c_gap", pop_cyc[1][1] - pop_cyc[1][0], 4 * LAT);
`ifdef POSIT_ACCUM_SCHED_STATS_EN
    chk("c_stat_bubbles", stat_bubbles - b0, 3);
`endif
    // Backpressure on the drain visit
    clr();
    out_ready = 1'b0;
    push(2, P2, 1'b0); push(2, P3, 1'b1);
    drive();
    wait_ov(2, 80, "d_ov_cnt");
    chk("d_no_accept", nsum, 0);
    chk("d_retry_gap", ov_cyc[1] - ov_cyc[0], LAT);
    chk("d_ov_data", ov_data[0], P5);
    chk("d_ov_id", ov_id[0], 2);
    out_ready = 1'b1;
    wait_sums(1, 20, "d_sum_cnt");
    chk("d_acc_data", rec_data[0], P5);
    chk("d_acc_cyc", rec_cyc[0], ov_cyc[0] + 2 * LAT);
    // Reuse the slot just cleared by the negation
    d = rec_cyc[0];
    slot_e = d % LAT;
    clr();
    while (cyc < d + LAT) step();
    push(2, P1, 1'b1);
    drive();
    wait_sums(1, 40, "e_sum_cnt");
    chk("e_data", rec_data[0], P1);
    chk("e_slot", pop_cyc[2][0] % LAT, slot_e);
    chk("e_cyc", rec_cyc[0], d + 2 * LAT);
    // NaR kills its slot
    clr();
    push(3, NAR, 1'b1);
    drive();
    wait_sums(1, 40, "f_sum_cnt");
    chk("f_inf", rec_inf[0], 1);
    chk("f_id", rec_id[0], 3);
    chk("f_err_dead", err_dead, 1);
    dead_slot = rec_cyc[0] % LAT;
    dead_hits = 0;
    clr();
    for (int k = 0; k < 10; k++) push(0, P1, 1'b1);
    drive();
    wait_sums(10, 300, "f_sweep_cnt");
    chk("f_dead_hits", dead_hits, 0);
    chk("f_sweep_data", rec_data[9], P1);
    chk("f_sweep_inf", rec_inf[9], 0);
    chk("f_err_sticky", err_dead, 1);
    // Reset revives the dead slot
    enter_reset();
    chk("r_err_dead", err_dead, 0);
    for (int k = 0; k < 10; k++) push(0, P1, 1'b1);
    drive();
    rst_n = 1'b1;
    wait_sums(10, 300, "r_sweep_cnt");
    chk("r_dead_reused", dead_hits > 0, 1);
    chk("r_sweep_data", rec_data[9], P1);
    chk("protocol_viol", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
